// File: rtl/iterative_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle.
// Signed and unsigned modes; valid/ready on both sides.
module iterative_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] sub;
  logic             ge;
  logic             unused_sub_bit;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x,
    input logic             sgn
  );
    return (sgn & x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  // Trial subtract: remainder keeps the shifted-out bit so large
  // divisors compare correctly; subtract is add of ~den plus one.
  always_comb begin
    rem_sh = {rem_q, num_q[WIDTH-1]};
    sub    = {1'b0, rem_sh}
           + {1'b0, ~{1'b0, den_q}}
           + {{(WIDTH+1){1'b0}}, 1'b1};
    ge     = sub[WIDTH+1];
  end

  assign unused_sub_bit = sub[WIDTH];

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    den_d     = den_q;
    rem_d     = rem_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_q_d = is_signed
                  & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_d = is_signed & dividend[WIDTH-1];
          num_d   = mag(dividend, is_signed);
          den_d   = mag(divisor, is_signed);
          rem_d   = '0;
          cnt_d   = '0;
          if (divisor == '0) begin
            state_d   = DONE;
            quo_out_d = '0;
            rem_out_d = dividend;
            dbz_d     = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = ge ? sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        num_d = {num_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        quo_out_d = neg_q_q ? (~num_q + 1'b1) : num_q;
        rem_out_d = neg_r_q ? (~rem_q + 1'b1) : rem_q;
        dbz_d     = 1'b0;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      num_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      den_q     <= den_d;
      rem_q     <= rem_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed vector table plus handshake, reset and
// random checks for the iterative divider.
module tb_iterative_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[14];

  iterative_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .is_signed  (is_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  // One full operation; hold = cycles of backpressure.
  task automatic do_op(input vec_t v, input int hold);
    int n;
    logic busy_bad;
    int exp_lat;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    dividend  = v.a;
    divisor   = v.b;
    is_signed = v.sgn;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    busy_bad = 1'b0;
    while (!out_valid && n < 200) begin
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    exp_lat = v.dbz ? 1 : W + 2;
    check("in_ready_busy", 64'(busy_bad), 64'd0);
    check("latency", 64'(n + 1), 64'(exp_lat));
    check("quotient", quotient, v.q);
    check("remainder", remainder, v.r);
    check("div_by_zero", 64'(div_by_zero), 64'(v.dbz));
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      dividend  = 64'd999;
      divisor   = 64'd3;
      @(posedge clk);
      #1;
      if (i == hold - 1) begin
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_ready", 64'(in_ready), 64'd0);
        check("bp_q", quotient, v.q);
        check("bp_r", remainder, v.r);
        check("bp_dbz", 64'(div_by_zero), 64'(v.dbz));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_valid_low", 64'(out_valid), 64'd0);
    check("hs_in_ready", 64'(in_ready), 64'd1);
    check("hs_dbz_clr", 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    vec_t v;
    longint sa, sb;
    int bad;
    vecs[0]  = '{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0};
    vecs[1]  = '{-64'sd100, 64'd7, 1'b1,
                 -64'sd14, -64'sd2, 1'b0};
    vecs[2]  = '{64'd100, -64'sd7, 1'b1,
                 -64'sd14, 64'd2, 1'b0};
    vecs[3]  = '{-64'sd100, -64'sd7, 1'b1,
                 64'd14, -64'sd2, 1'b0};
    vecs[4]  = '{64'h1234, 64'd0, 1'b0,
                 64'd0, 64'h1234, 1'b1};
    vecs[5]  = '{-64'sd5, 64'd0, 1'b1,
                 64'd0, -64'sd5, 1'b1};
    vecs[6]  = '{MIN, ONES, 1'b1, MIN, 64'd0, 1'b0};
    vecs[7]  = '{MIN, ONES, 1'b0, 64'd0, MIN, 1'b0};
    vecs[8]  = '{64'd5, 64'd9, 1'b0, 64'd0, 64'd5, 1'b0};
    vecs[9]  = '{ONES, 64'h8000_0000_0000_0001, 1'b0,
                 64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[10] = '{ONES, 64'd1, 1'b0, ONES, 64'd0, 1'b0};
    vecs[11] = '{64'd7, -64'sd7, 1'b1, ONES, 64'd0, 1'b0};
    vecs[12] = '{ONES, 64'd2, 1'b1, 64'd0, ONES, 1'b0};
    vecs[13] = '{ONES, 64'd2, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_q", quotient, 64'd0);
    check("rst_r", remainder, 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) do_op(vecs[i], 0);

    // Backpressure on a normal and a zero-divisor result.
    do_op(vecs[0], 10);
    do_op(vecs[4], 10);

    // Outputs now hold 14/2; reset in the middle of CALC.
    do_op(vecs[0], 0);
    @(negedge clk);
    dividend  = 64'd1000;
    divisor   = 64'd3;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_in_ready", 64'(in_ready), 64'd1);
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_q", quotient, 64'd0);
    check("mid_r", remainder, 64'd0);
    check("mid_dbz", 64'(div_by_zero), 64'd0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    check("abort_no_result", 64'(bad), 64'd0);

    // Random operands against language arithmetic.
    for (int i = 0; i < 20; i++) begin
      v.a   = {$urandom, $urandom};
      v.b   = {$urandom, $urandom};
      v.sgn = i[0];
      if (i % 4 == 2) v.b = 64'($urandom_range(1, 300));
      if (i % 4 == 3) v.b = -64'($urandom_range(1, 300));
      if (v.b == 64'd0) v.b = 64'd3;
      if (v.sgn && v.a == MIN && v.b == ONES) v.b = 64'd5;
      v.dbz = 1'b0;
      if (v.sgn) begin
        sa  = longint'(v.a);
        sb  = longint'(v.b);
        v.q = 64'(sa / sb);
        v.r = 64'(sa % sb);
      end else begin
        v.q = v.a / v.b;
        v.r = v.a % v.b;
      end
      do_op(v, i % 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
